restoring_div_seq: RTL and testbench

RESTORING_DIV_SEQ -- requirements
Module: restoring_div_seq

---
 rtl/div_pkg.sv | 10 +
 rtl/restoring_div_seq_ripple_sub.sv | 36 +++
 rtl/restoring_div_seq.sv | 88 ++++++++
 tb/tb_restoring_div_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and default operand width for the restoring divider
// Ports: none (package); exports state_t {IDLE, RUN, DONE} and DIV_WIDTH
package div_pkg;
   localparam int DIV_WIDTH = 8;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/restoring_div_seq_ripple_sub.sv
// ripple_sub: W-bit ripple-borrow subtractor (a - b) chained from one-bit full-subtractor cells
// Ports: a, b (W bits) -> diff (W bits), borrow_out (high when b > a)
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module ripple_sub
   import div_pkg::*;
#(
   parameter int W = DIV_WIDTH + 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow_out
);
   logic [W:0] br;
   assign br[0] = 1'b0;
   for (genvar i = 0; i < W; i++) begin : g_cell
      full_sub u_fs (
         .a(a[i]),
         .b(b[i]),
         .bin(br[i]),
         .d(diff[i]),
         .bout(br[i+1])
      );
   end
   assign borrow_out = br[W];
endmodule

// File: rtl/restoring_div_seq.sv
// restoring_div_seq: sequential unsigned restoring divider producing one quotient bit per clock
// Ports: clk, rst (sync, active-high), start, dividend, divisor -> busy, done, quotient, remainder, dz
// Option: define DIV_ZERO_DETECT_EN to short-circuit a zero divisor to DONE with dz=1
module restoring_div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dz
);
   localparam int CW = $clog2(WIDTH);
`ifdef DIV_ZERO_DETECT_EN
   localparam bit ZERO_DETECT = 1'b1;
`else
   localparam bit ZERO_DETECT = 1'b0;
`endif
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem, rem_sh, rem_n, diff;
   logic [WIDTH-1:0] dq, dq_n, dvs, q_r, r_r;
   logic             borrow, dz_r, zero_skip;
   // dq starts as the dividend and fills with quotient bits from the right as it shifts out
   assign rem_sh = (WIDTH+1)'({rem, dq[WIDTH-1]});
   ripple_sub #(.W(WIDTH + 1)) u_sub (
      .a(rem_sh),
      .b({1'b0, dvs}),
      .diff(diff),
      .borrow_out(borrow)
   );
   assign rem_n     = borrow ? rem_sh : diff;
   assign dq_n      = {dq[WIDTH-2:0], ~borrow};
   assign zero_skip = ZERO_DETECT && (dvs == '0);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         dq    <= '0;
         dvs   <= '0;
         q_r   <= '0;
         r_r   <= '0;
         dz_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               dq    <= dividend;
               dvs   <= divisor;
               rem   <= '0;
               cnt   <= CW'(WIDTH - 1);
               state <= RUN;
            end
            RUN: if (zero_skip) begin
               // dq still holds the untouched dividend on the first RUN cycle
               q_r   <= '1;
               r_r   <= dq;
               dz_r  <= 1'b1;
               state <= DONE;
            end else begin
               rem <= rem_n;
               dq  <= dq_n;
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  q_r   <= dq_n;
                  r_r   <= rem_n[WIDTH-1:0];
                  dz_r  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   assign busy      = state != IDLE;
   assign done      = state == DONE;
   assign quotient  = q_r;
   assign remainder = r_r;
   assign dz        = dz_r;
endmodule

// File: tb/tb_restoring_div_seq.sv
// tb_restoring_div_seq: self-checking bench for restoring_div_seq (WIDTH=8), directed table, corner sequences and random sweep
module tb_restoring_div_seq;
   localparam int W = 8;
`ifdef DIV_ZERO_DETECT_EN
   localparam int ZLAT = 2;
   localparam bit ZDZ  = 1'b1;
`else
   localparam int ZLAT = W + 1;
   localparam bit ZDZ  = 1'b0;
`endif
   logic         clk = 1'b0;
   logic         rst, start;
   logic [W-1:0] dividend, divisor, quotient, remainder;
   logic         busy, done, dz;
   int           pass_cnt = 0;
   int           total = 0;

   typedef struct {
      logic [W-1:0] a, b, q, r;
      int           lat;
      bit           z;
   } vec_t;
   vec_t vecs[9];

   always #5 clk = ~clk;

   restoring_div_seq #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .dz(dz)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // start accepted at the posedge following this call (edge N)
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // lat = k means done was first observed as sampled by edge N+k; 0 means timeout
   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            return;
         end
      end
   endtask

   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input bit ez, input int el, input string tag);
      int lat;
      launch(a, b);
      wait_done(lat);
      check({tag, " latency"}, lat, el);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " dz"}, dz, ez);
      @(negedge clk);
      check({tag, " done single pulse"}, done, 1'b0);
      check({tag, " busy idle"}, busy, 1'b0);
      check({tag, " quotient held"}, quotient, eq);
   endtask

   initial begin
      int lat, cnt;
      logic [W-1:0] a, b, eq, er, cq, cr;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset dz", dz, 1'b0);

      vecs[0] = '{a: 100, b: 7,   q: 14,  r: 2,   lat: W + 1, z: 1'b0};
      vecs[1] = '{a: 255, b: 1,   q: 255, r: 0,   lat: W + 1, z: 1'b0};
      vecs[2] = '{a: 5,   b: 9,   q: 0,   r: 5,   lat: W + 1, z: 1'b0};
      vecs[3] = '{a: 37,  b: 0,   q: 255, r: 37,  lat: ZLAT,  z: ZDZ};
      vecs[4] = '{a: 200, b: 10,  q: 20,  r: 0,   lat: W + 1, z: 1'b0};
      vecs[5] = '{a: 0,   b: 5,   q: 0,   r: 0,   lat: W + 1, z: 1'b0};
      vecs[6] = '{a: 255, b: 255, q: 1,   r: 0,   lat: W + 1, z: 1'b0};
      vecs[7] = '{a: 1,   b: 255, q: 0,   r: 1,   lat: W + 1, z: 1'b0};
      vecs[8] = '{a: 0,   b: 0,   q: 255, r: 0,   lat: ZLAT,  z: ZDZ};
      for (int i = 0; i < 9; i++)
         run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat, $sformatf("vec%0d", i));

      // a second start at N+3 must be ignored
      launch(100, 7);
      cnt = 0; lat = 0; cq = '0; cr = '0;
      for (int k = 1; k <= W + 6; k++) begin
         @(negedge clk);
         if (k == 3) begin start = 1'b1; dividend = 9; divisor = 3; end
         if (k == 4) start = 1'b0;
         if (done) begin cnt++; lat = k; cq = quotient; cr = remainder; end
      end
      check("restart done count", cnt, 1);
      check("restart latency", lat, W + 1);
      check("restart quotient", cq, 14);
      check("restart remainder", cr, 2);
      check("restart busy after", busy, 1'b0);

      // reset at N+4 discards the division
      launch(100, 7);
      for (int k = 1; k <= 4; k++) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrun rst busy", busy, 1'b0);
      check("midrun rst done", done, 1'b0);
      check("midrun rst quotient", quotient, 0);
      check("midrun rst remainder", remainder, 0);
      check("midrun rst dz", dz, 1'b0);
      cnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done || busy) cnt++;
      end
      check("midrun rst no activity", cnt, 0);
      run_div(200, 10, 20, 0, 1'b0, W + 1, "after rst");

      // reset wins over a coincident start
      @(negedge clk);
      rst = 1'b1; start = 1'b1; dividend = 3; divisor = 1;
      @(posedge clk);
      #1 rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst over start busy", busy, 1'b0);
      @(negedge clk);
      check("rst over start still idle", busy, 1'b0);

      // random back-to-back sweep against arithmetic reference
      for (int i = 0; i < 60; i++) begin
         a = W'($urandom_range(0, 255));
         b = (i % 10 == 0) ? '0 : W'($urandom_range(0, 255));
         eq = (b == 0) ? '1 : a / b;
         er = (b == 0) ? a : a % b;
         launch(a, b);
         wait_done(lat);
         check("rand latency", lat, (b == 0) ? ZLAT : W + 1);
         check("rand quotient", quotient, eq);
         check("rand remainder", remainder, er);
         if (b != 0) begin
            check("rand identity", 16'(quotient) * 16'(b) + 16'(remainder), 16'(a));
            check("rand rem lt div", remainder < b, 1'b1);
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
